// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-port round-robin arbiter with bounded burst lock for a single-port RAM
module mem_bus_arbiter #(
    parameter int AW       = 12,
    parameter int DW       = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          lock0,
    input  logic          we0,
    input  logic [3:0]    wmask0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          lock1,
    input  logic          we1,
    input  logic [3:0]    wmask1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic          mem_en,
    output logic          mem_we,
    output logic [3:0]    mem_wmask,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = $clog2(MAX_LOCK) + 1;
    localparam logic [CW-1:0] LOCK_LAST = CW'(MAX_LOCK - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          rr_last, rr_last_nxt;
    logic [CW-1:0] lock_cnt, lock_cnt_nxt;
    logic          rd_pend, rd_sel;

    logic          grant;      // an access is issued this cycle
    logic          sel;        // which port owns the issued access
    logic          owner;      // lock owner when in a LOCK state
    logic          owner_hold; // owner still requesting with lock held
    logic          idle_req;
    logic          idle_sel;

    // State register: FSM, round-robin pointer and lock counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_last  <= 1'b1;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            rr_last  <= rr_last_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end

    // Arbitration: locked owner first, otherwise round-robin with optional lock entry
    always_comb begin
        state_nxt    = state;
        rr_last_nxt  = rr_last;
        lock_cnt_nxt = lock_cnt;
        grant        = 1'b0;
        sel          = 1'b0;
        owner        = (state == LOCK1);
        owner_hold   = 1'b0;
        idle_req     = req0 | req1;
        idle_sel     = (req0 && req1) ? ~rr_last : req1;

        case (state)
            LOCK0:   owner_hold = req0 & lock0;
            LOCK1:   owner_hold = req1 & lock1;
            default: owner_hold = 1'b0;
        endcase

        if (state != IDLE && owner_hold) begin
            grant       = 1'b1;
            sel         = owner;
            rr_last_nxt = owner;
            if (lock_cnt == LOCK_LAST) begin
                // Forced release: rr_last=owner hands the next tie to the other port
                state_nxt    = IDLE;
                lock_cnt_nxt = '0;
            end else begin
                lock_cnt_nxt = lock_cnt + CW'(1);
            end
        end else begin
            // Plain arbitration; a lock is dropped (or owner idle) falls through here too
            state_nxt    = IDLE;
            lock_cnt_nxt = '0;
            if (idle_req) begin
                grant       = 1'b1;
                sel         = idle_sel;
                rr_last_nxt = idle_sel;
                if (state == IDLE && MAX_LOCK > 1 && (idle_sel ? lock1 : lock0)) begin
                    state_nxt    = idle_sel ? LOCK1 : LOCK0;
                    lock_cnt_nxt = CW'(1);
                end
            end
        end

        if (!rst_n) begin
            grant = 1'b0;
        end
    end

    assign gnt0      = grant & ~sel;
    assign gnt1      = grant & sel;
    assign mem_en    = grant;
    assign mem_we    = grant & (sel ? we1 : we0);
    assign mem_wmask = sel ? wmask1 : wmask0;
    assign mem_addr  = sel ? addr1 : addr0;
    assign mem_wdata = sel ? wdata1 : wdata0;

    // Read return tracking: remember which port issued the read one cycle ago
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pend <= 1'b0;
            rd_sel  <= 1'b0;
        end else begin
            rd_pend <= mem_en & ~mem_we;
            rd_sel  <= sel;
        end
    end

    assign rvalid0 = rst_n & rd_pend & ~rd_sel;
    assign rvalid1 = rst_n & rd_pend & rd_sel;
    assign rdata0  = rvalid0 ? mem_rdata : '0;
    assign rdata1  = rvalid1 ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 0, lock0 = 0, we0 = 0;
    logic [3:0]  wmask0 = 0;
    logic [11:0] addr0 = 0;
    logic [31:0] wdata0 = 0;
    logic        gnt0, rvalid0;
    logic [31:0] rdata0;
    logic        req1 = 0, lock1 = 0, we1 = 0;
    logic [3:0]  wmask1 = 0;
    logic [11:0] addr1 = 0;
    logic [31:0] wdata1 = 0;
    logic        gnt1, rvalid1;
    logic [31:0] rdata1;
    logic        mem_en, mem_we;
    logic [3:0]  mem_wmask;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 0;

    mem_bus_arbiter #(.AW(12), .DW(32), .MAX_LOCK(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .lock0(lock0), .we0(we0), .wmask0(wmask0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .lock1(lock1), .we1(we1), .wmask1(wmask1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  m;
        logic [11:0] a;
        logic [31:0] d;
        logic        lk;
    } cmd_t;

    typedef struct {
        logic        p;
        logic        we;
        logic [11:0] a;
        logic [3:0]  m;
        logic [31:0] d;
    } gexp_t;

    cmd_t        q0[$];
    cmd_t        q1[$];
    gexp_t       gq[$];
    logic [31:0] rq0[$];
    logic [31:0] rq1[$];

    int checks = 0;
    int passed = 0;

    logic [31:0] ram [0:4095];
    logic        pre_en = 0;
    logic [11:0] pre_a = 0;
    logic [31:0] pre_d = 0;

    // Behavioural single-port RAM with 1-cycle read latency and byte mask
    always @(posedge clk) begin
        if (pre_en) begin
            ram[pre_a] <= pre_d;
        end else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wmask[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail(input string name);
        checks++;
        $display("FAIL %s: got event expected none", name);
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_en = 1'b1; pre_a = a; pre_d = d;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic issue(input logic p, input logic we, input logic [11:0] a, input logic [31:0] d,
                         input logic [3:0] m, input logic lk, input logic exp_rd, input logic [31:0] rexp);
        cmd_t  c;
        gexp_t g;
        c.we = we; c.m = m; c.a = a; c.d = d; c.lk = lk;
        g.p = p; g.we = we; g.a = a; g.m = m; g.d = d;
        if (p) q1.push_back(c); else q0.push_back(c);
        gq.push_back(g);
        if (!we && exp_rd) begin
            if (p) rq1.push_back(rexp); else rq0.push_back(rexp);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((q0.size() + q1.size() + gq.size() + rq0.size() + rq1.size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            $display("FAIL %s_timeout: got %0d pending expected 0", name,
                     q0.size() + q1.size() + gq.size() + rq0.size() + rq1.size());
            q0.delete(); q1.delete(); gq.delete(); rq0.delete(); rq1.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Port 0 requester: holds the head command until a grant is seen
    initial begin
        logic g;
        forever begin
            @(negedge clk); g = gnt0;
            @(posedge clk);
            if (g && q0.size() > 0) void'(q0.pop_front());
            #1;
            if (q0.size() > 0) begin
                req0 = 1; we0 = q0[0].we; wmask0 = q0[0].m; addr0 = q0[0].a; wdata0 = q0[0].d; lock0 = q0[0].lk;
            end else begin
                req0 = 0; we0 = 0; lock0 = 0;
            end
        end
    end

    // Port 1 requester
    initial begin
        logic g;
        forever begin
            @(negedge clk); g = gnt1;
            @(posedge clk);
            if (g && q1.size() > 0) void'(q1.pop_front());
            #1;
            if (q1.size() > 0) begin
                req1 = 1; we1 = q1[0].we; wmask1 = q1[0].m; addr1 = q1[0].a; wdata1 = q1[0].d; lock1 = q1[0].lk;
            end else begin
                req1 = 0; we1 = 0; lock1 = 0;
            end
        end
    end

    // Monitor: grants in expected order, rvalid one cycle after read grant, read data
    initial begin
        logic  prv0, prv1, ev0, ev1;
        gexp_t g;
        prv0 = 0; prv1 = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("reset_outputs", {gnt0, gnt1, mem_en, mem_we, rvalid0, rvalid1}, 6'b0);
            end else begin
                if (gnt0 || gnt1 || mem_en) begin
                    if (gq.size() == 0) fail("grant_unexpected");
                    else begin
                        g = gq.pop_front();
                        check("grant", {mem_en, gnt1, gnt0, mem_we, mem_addr},
                              {1'b1, g.p, ~g.p, g.we, g.a});
                        if (g.we) check("write_payload", {mem_wmask, mem_wdata}, {g.m, g.d});
                    end
                end
                ev0 = prv0; ev1 = prv1;
                if (rvalid0 || ev0) check("rvalid0_timing", rvalid0, ev0);
                if (rvalid1 || ev1) check("rvalid1_timing", rvalid1, ev1);
                if (rvalid0) begin
                    if (rq0.size() == 0) fail("rvalid0_unexpected");
                    else check("rdata0", rdata0, rq0.pop_front());
                    check("rdata1_idle", rdata1, 0);
                end
                if (rvalid1) begin
                    if (rq1.size() == 0) fail("rvalid1_unexpected");
                    else check("rdata1", rdata1, rq1.pop_front());
                    check("rdata0_idle", rdata0, 0);
                end
            end
            prv0 = rst_n && gnt0 && !mem_we;
            prv1 = rst_n && gnt1 && !mem_we;
        end
    end

    // Directed stimulus
    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single read
        preload(12'h010, 32'hDEADBEEF);
        @(negedge clk);
        issue(0, 0, 12'h010, 0, 4'h0, 0, 1, 32'hDEADBEEF);
        drain("single_read");

        // Round-robin contention straight after reset
        preload(12'h001, 32'h11111111);
        preload(12'h002, 32'h22222222);
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            issue(0, 0, 12'h001, 0, 4'h0, 0, 1, 32'h11111111);
            issue(1, 0, 12'h002, 0, 4'h0, 0, 1, 32'h22222222);
        end
        drain("round_robin");

        // Write by port1, read by port0 on the next cycle
        @(negedge clk);
        issue(1, 1, 12'h020, 32'h55AA55AA, 4'b1111, 0, 0, 0);
        @(negedge clk);
        issue(0, 0, 12'h020, 0, 4'h0, 0, 1, 32'h55AA55AA);
        drain("write_then_read");

        // Byte mask
        preload(12'h030, 32'h11223344);
        @(negedge clk);
        issue(0, 1, 12'h030, 32'hFFFFFFFF, 4'b0010, 0, 0, 0);
        issue(0, 0, 12'h030, 0, 4'h0, 0, 1, 32'h1122FF44);
        drain("byte_mask");

        // Bounded lock: port1 locks, port0 competes from the next cycle
        @(negedge clk);
        for (int k = 0; k < 8; k++)
            issue(1, 1, 12'h100 + 12'(k), 32'hA0000100 + 32'(k), 4'hF, 1, 0, 0);
        @(negedge clk);
        q0.push_back('{we: 1'b0, m: 4'h0, a: 12'h100, d: 32'h0, lk: 1'b0});
        q0.push_back('{we: 1'b0, m: 4'h0, a: 12'h107, d: 32'h0, lk: 1'b0});
        gq.push_back('{p: 1'b0, we: 1'b0, a: 12'h100, m: 4'h0, d: 32'h0});
        rq0.push_back(32'hA0000100);
        for (int k = 8; k < 16; k++) begin
            q1.push_back('{we: 1'b1, m: 4'hF, a: 12'h100 + 12'(k), d: 32'hA0000100 + 32'(k), lk: 1'b1});
            gq.push_back('{p: 1'b1, we: 1'b1, a: 12'h100 + 12'(k), m: 4'hF, d: 32'hA0000100 + 32'(k)});
        end
        gq.push_back('{p: 1'b0, we: 1'b0, a: 12'h107, m: 4'h0, d: 32'h0});
        rq0.push_back(32'hA0000107);
        drain("bounded_lock");

        // Reset with a read in flight
        preload(12'h040, 32'hCAFEF00D);
        @(negedge clk);
        issue(0, 0, 12'h040, 0, 4'h0, 0, 0, 0);
        n = 0;
        while (!gnt0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("reset_read_granted", gnt0, 1'b1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        check("reset_kills_rvalid0", {rvalid0, rvalid1}, 2'b00);
        issue(0, 0, 12'h001, 0, 4'h0, 0, 1, 32'h11111111);
        issue(1, 0, 12'h002, 0, 4'h0, 0, 1, 32'h22222222);
        @(negedge clk);
        check("reset_gates_grants", {req0, req1, gnt0, gnt1, mem_en, rvalid0}, 6'b110000);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("first_grant_after_reset", {gnt0, gnt1}, 2'b10);
        drain("reset_mid_read");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
